// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: length-prefixed, XOR-checksummed image,
// little-endian 32-bit words written at byte addresses; core held in reset until a clean load.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_rst_n
);

  localparam int unsigned IW = $clog2(MAX_WORDS) + 1;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR} state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [IW-1:0]     widx_q, widx_d;
  logic [7:0]        csum_q, csum_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        accept;
  logic [15:0] len_full;
  logic        last_word;

  assign byte_ready = (state_q == LEN0) || (state_q == LEN1) ||
                      (state_q == DATA) || (state_q == CSUM);
  assign busy       = byte_ready;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERROR);
  assign cpu_rst_n  = (state_q == DONE);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  assign accept    = byte_valid && byte_ready;
  assign len_full  = {byte_data, len_q[7:0]};
  assign last_word = ((16'(widx_q) + 16'd1) == len_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    csum_d  = csum_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LEN0;
          len_d   = '0;
          cnt_d   = '0;
          widx_d  = '0;
          csum_d  = '0;
        end
      end
      LEN0: begin
        if (accept) begin
          len_d[7:0] = byte_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d[15:8] = byte_data;
          if ((len_full == '0) || (32'(len_full) > MAX_WORDS)) state_d = ERROR;
          else                                                 state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          csum_d = csum_q ^ byte_data;
          cnt_d  = cnt_q + 2'd1;
          unique case (cnt_q)
            2'd0: asm_d[7:0]   = byte_data;
            2'd1: asm_d[15:8]  = byte_data;
            2'd2: asm_d[23:16] = byte_data;
            default: begin
              // Strobe is registered, so the write lands one clock after lane 3.
              we_d    = 1'b1;
              addr_d  = ADDR_W'(widx_q) << 2;
              wdata_d = {byte_data, asm_q};
              widx_d  = widx_q + IW'(1);
              if (last_word) state_d = CSUM;
            end
          endcase
        end
      end
      CSUM: begin
        if (accept) state_d = (byte_data == csum_q) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      widx_q  <= '0;
      csum_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      csum_q  <= csum_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: stream-position reference model plus
// literal expectations for the hand-computed images.
module tb_imem_loader;

  localparam int MAXW = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, mem_we, busy, done, error, cpu_rst_n;
  logic [31:0] mem_addr, mem_wdata;

  imem_loader #(.MAX_WORDS(MAXW), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .error(error), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the load by position in the byte stream.
  logic        m_active, m_done, m_err, m_we;
  int          m_pos, m_n;
  logic [7:0]  m_x;
  logic [31:0] m_word, m_addr, m_wdata;

  task automatic model_reset();
    m_active = 0; m_done = 0; m_err = 0; m_we = 0;
    m_pos = 0; m_n = 0; m_x = '0; m_word = '0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_edge();
    int k;
    m_we = 0;
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_done = 0; m_err = 0;
        m_pos = 0; m_n = 0; m_x = '0; m_word = '0;
      end
    end else if (byte_valid) begin
      if (m_pos == 0) m_n = int'(byte_data);
      else if (m_pos == 1) begin
        m_n = m_n + int'(byte_data) * 256;
        if (m_n == 0 || m_n > MAXW) begin m_active = 0; m_err = 1; end
      end else if (m_pos < 2 + 4 * m_n) begin
        k = m_pos - 2;
        m_x = m_x ^ byte_data;
        m_word = m_word | ({24'b0, byte_data} << (8 * (k % 4)));
        if (k % 4 == 3) begin
          m_we = 1; m_addr = 32'((k / 4) * 4); m_wdata = m_word; m_word = '0;
        end
      end else begin
        m_active = 0;
        if (byte_data == m_x) m_done = 1; else m_err = 1;
      end
      m_pos++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
  endtask

  logic [31:0] cap_mem [32];
  int          n_strobe = 0;
  logic [31:0] last_addr = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("byte_ready", byte_ready, m_active);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("cpu_rst_n", cpu_rst_n, m_done);
      chk("mem_we", mem_we, m_we);
      if (m_we) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (mem_we) begin
        cap_mem[mem_addr[6:2]] = mem_wdata;
        n_strobe++;
        last_addr = mem_addr;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      byte_valid = 1'($urandom); byte_data = 8'($urandom); step();
    end
    byte_valid = 0;
  endtask

  task automatic send(input logic [7:0] s[$], input int maxgap, input int rst_at, input int start_at);
    byte_valid = 0;
    start = 1; step(); start = 0;
    foreach (s[i]) begin
      if (i == rst_at) begin
        rst_n = 0; #1;
        chk("rst_byte_ready", byte_ready, 0); chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);     chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);             chk("rst_done", done, 0);
        chk("rst_error", error, 0);           chk("rst_cpu_rst_n", cpu_rst_n, 0);
        repeat (3) begin step(); chk("mem_we_in_rst", mem_we, 0); end
        rst_n = 1; byte_valid = 0;
        return;
      end
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) begin
        byte_valid = 0; byte_data = 8'($urandom); step();
      end
      byte_valid = 1; byte_data = s[i]; start = (i == start_at); step(); start = 0;
    end
    byte_valid = 0;
  endtask

  task automatic build_img(input int n, input bit bad, output logic [7:0] q[$]);
    logic [7:0] x, b;
    q = {};
    q.push_back(n[7:0]); q.push_back(n[15:8]);
    x = '0;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom); q.push_back(b); x = x ^ b;
    end
    q.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] good[$], bad[$], one[$], img[$];
    int s0;
    good = {8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'h13, 8'h03, 8'h30, 8'h00, 8'hE1};
    bad  = {8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'h13, 8'h03, 8'h30, 8'h00, 8'hE0};
    one  = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    model_reset();
    repeat (3) step();
    chk("reset_byte_ready", byte_ready, 0); chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_addr", mem_addr, 0);     chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_busy", busy, 0);             chk("reset_done", done, 0);
    chk("reset_error", error, 0);           chk("reset_cpu_rst_n", cpu_rst_n, 0);
    rst_n = 1;
    idle(6);

    // Good 2-word load at full rate.
    s0 = n_strobe;
    send(good, 0, -1, -1); step();
    chk("good_strobes", n_strobe - s0, 2);
    chk("good_word0", cap_mem[0], 32'h00500293);
    chk("good_word1", cap_mem[1], 32'h00300313);
    chk("good_done", done, 1); chk("good_cpu_rst_n", cpu_rst_n, 1);
    idle(4);

    // Reload after done: done and cpu_rst_n drop on the start edge.
    start = 1; step(); start = 0;
    chk("reload_done_cleared", done, 0); chk("reload_cpu_rst_n", cpu_rst_n, 0);
    chk("reload_busy", busy, 1);
    model_reset(); rst_n = 0; #1; rst_n = 1;
    s0 = n_strobe;
    send(one, 0, -1, -1); step();
    chk("one_strobes", n_strobe - s0, 1);
    chk("one_word0", cap_mem[0], 32'h00000013);
    chk("one_done", done, 1);
    idle(3);

    // Bad checksum.
    s0 = n_strobe;
    send(bad, 0, -1, -1); step();
    chk("bad_strobes", n_strobe - s0, 2);
    chk("bad_error", error, 1); chk("bad_done", done, 0);
    chk("bad_cpu_rst_n", cpu_rst_n, 0); chk("bad_byte_ready", byte_ready, 0);
    idle(3);

    // Length bounds: N=0 and N=33, extra bytes afterwards are not consumed.
    s0 = n_strobe;
    send({8'h00, 8'h00, 8'h11, 8'h22}, 0, -1, -1); step();
    chk("len0_error", error, 1);
    send({8'h21, 8'h00, 8'h11, 8'h22}, 0, -1, -1); step();
    chk("len33_error", error, 1);
    chk("len_bad_strobes", n_strobe - s0, 0);
    idle(3);

    // N=32 at full rate.
    s0 = n_strobe;
    build_img(32, 1'b0, img);
    send(img, 0, -1, -1); step();
    chk("n32_strobes", n_strobe - s0, 32);
    chk("n32_last_addr", last_addr, 32'h7C);
    chk("n32_done", done, 1);

    // Throttled source.
    s0 = n_strobe;
    send(good, 5, -1, -1); step();
    chk("thr_strobes", n_strobe - s0, 2);
    chk("thr_word1", cap_mem[1], 32'h00300313);
    chk("thr_done", done, 1);

    // Reset after 6 payload bytes, then a fresh good load.
    send(good, 0, 8, -1);
    idle(2);
    send(good, 0, -1, -1); step();
    chk("post_rst_done", done, 1);
    chk("post_rst_word0", cap_mem[0], 32'h00500293);

    // Randomized loads: lengths, throttling, checksum faults, start pulses mid-load.
    for (int it = 0; it < 6; it++) begin
      int n;
      n = int'($urandom_range(1, MAXW));
      build_img(n, ($urandom_range(0, 3) == 0), img);
      send(img, int'($urandom_range(0, 3)), -1, int'($urandom_range(1, 4 * n)));
      idle(int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
